mult_share_arbiter: RTL and testbench

//  Shares one pipelined signed 14x12 multiplier (26-bit product, MULT_LAT-cycle

---
 rtl/mult_share_arbiter_if.sv | 27 ++
 rtl/mult_share_arbiter.sv | 97 +++++++++
 tb/tb_mult_share_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arbiter_if.sv
// Requester-side and multiplier-side signals of the shared-multiplier arbiter.
// The arbiter uses the slave view; the requester/multiplier environment uses master.
interface mult_share_arbiter_if #(
  parameter int N_REQ = 4
);
  logic                 en;
  logic [N_REQ-1:0]     req;
  logic [N_REQ*14-1:0]  req_a;
  logic [N_REQ*12-1:0]  req_b;
  logic [N_REQ-1:0]     grant;
  logic [13:0]          mult_dataa;
  logic [11:0]          mult_datab;
  logic [25:0]          mult_result;
  logic [N_REQ-1:0]     res_valid;
  logic [25:0]          res_data;
  logic                 busy;

  modport slave (
    input  en, req, req_a, req_b, mult_result,
    output grant, mult_dataa, mult_datab, res_valid, res_data, busy
  );

  modport master (
    output en, req, req_a, req_b, mult_result,
    input  grant, mult_dataa, mult_datab, res_valid, res_data, busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one pipelined signed 14x12 multiplier among N_REQ requesters;
// a {valid,id} tag pipeline routes each product back as a one-cycle strobe.
module mult_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MULT_LAT = 2,
  parameter int ID_W     = 2
) (
  input logic                 clock,
  input logic                 reset_n,
  mult_share_arbiter_if.slave bus
);
  logic [ID_W-1:0]  ptr_reg;
  logic [13:0]      a_slice [N_REQ];
  logic [11:0]      b_slice [N_REQ];
  logic             gnt_any;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  scan_id;
  logic [13:0]      dataa_reg;
  logic [11:0]      datab_reg;
  logic [MULT_LAT:0] tag_valid_reg;
  logic [ID_W-1:0]  tag_id_reg [MULT_LAT+1];
  logic [N_REQ-1:0] res_valid_reg;
  logic [25:0]      res_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign a_slice[gi] = bus.req_a[14*gi +: 14];
      assign b_slice[gi] = bus.req_b[12*gi +: 12];
    end
  endgenerate

  // Search upward from ptr+1 with wrap; first requesting index wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    scan_id = '0;
    if (reset_n && bus.en) begin
      for (int k = 1; k <= N_REQ; k++) begin
        scan_id = ID_W'((int'(ptr_reg) + k) % N_REQ);
        if (!gnt_any && bus.req[scan_id]) begin
          gnt_any = 1'b1;
          gnt_id  = scan_id;
        end
      end
    end
  end

  assign bus.grant = gnt_any ? (N_REQ'(1) << gnt_id) : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_reg   <= ID_W'(N_REQ - 1);
      dataa_reg <= '0;
      datab_reg <= '0;
    end else if (gnt_any) begin
      ptr_reg   <= gnt_id;
      dataa_reg <= a_slice[gnt_id];
      datab_reg <= b_slice[gnt_id];
    end
  end

  // Stage MULT_LAT lines up with the multiplier output for the same issue.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid_reg <= '0;
      for (int s = 0; s <= MULT_LAT; s++) begin
        tag_id_reg[s] <= '0;
      end
    end else begin
      tag_valid_reg[0] <= gnt_any;
      tag_id_reg[0]    <= gnt_id;
      for (int s = 1; s <= MULT_LAT; s++) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_id_reg[s]    <= tag_id_reg[s-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res_valid_reg <= '0;
      res_data_reg  <= '0;
    end else if (tag_valid_reg[MULT_LAT]) begin
      res_valid_reg <= N_REQ'(1) << tag_id_reg[MULT_LAT];
      res_data_reg  <= bus.mult_result;
    end else begin
      res_valid_reg <= '0;
    end
  end

  assign bus.mult_dataa = dataa_reg;
  assign bus.mult_datab = datab_reg;
  assign bus.res_valid  = res_valid_reg;
  assign bus.res_data   = res_data_reg;
  assign bus.busy       = (|tag_valid_reg) | (|res_valid_reg);
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a 2-stage signed multiplier model.
module tb_mult_share_arbiter;
  localparam int N_REQ    = 4;
  localparam int MULT_LAT = 2;
  localparam int ID_W     = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   n_vec   = 0;
  int   n_bad   = 0;

  logic signed [25:0] p1_reg;
  logic signed [25:0] p2_reg;

  mult_share_arbiter_if #(.N_REQ(N_REQ)) bus ();

  mult_share_arbiter #(
    .N_REQ(N_REQ),
    .MULT_LAT(MULT_LAT),
    .ID_W(ID_W)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clock = ~clock;

  // Multiplier: samples operands each edge, product two edges later.
  always @(posedge clock) begin
    p1_reg <= $signed(bus.mult_dataa) * $signed(bus.mult_datab);
    p2_reg <= p1_reg;
  end
  assign bus.mult_result = p2_reg;

  function automatic logic [31:0] wrap(input int v, input int bits);
    logic [31:0] m;
    m = (32'd1 << bits) - 32'd1;
    return 32'(v) & m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end else begin
      $display("  ok   %-12s %0h", tag, obs);
    end
  endtask

  task automatic set_op(input int id, input int a, input int b);
    bus.req_a[14*id +: 14] = 14'(a);
    bus.req_b[12*id +: 12] = 12'(b);
  endtask

  task automatic do_reset();
    bus.en  = 1'b1;
    bus.req = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // Lone requester id issues n pairs back-to-back; products expected 4 cycles later.
  task automatic stream(input string name, input int id, input int n,
                        input int av[8], input int bv[8], input int pv[8]);
    for (int c = 0; c < n + 5; c++) begin
      @(negedge clock);
      if (c < n) begin
        bus.req = 4'(1 << id);
        set_op(id, av[c], bv[c]);
      end else begin
        bus.req = '0;
      end
      #1;
      check({name, "_gnt"}, 32'(bus.grant), (c < n) ? (32'd1 << id) : 32'd0);
      if (c == 1) begin
        check({name, "_da"}, 32'(bus.mult_dataa), wrap(av[0], 14));
        check({name, "_db"}, 32'(bus.mult_datab), wrap(bv[0], 12));
        check({name, "_busy1"}, 32'(bus.busy), 32'd1);
      end
      if (c >= 4 && c < n + 4) begin
        check({name, "_rv"}, 32'(bus.res_valid), 32'd1 << id);
        check({name, "_rd"}, 32'(bus.res_data), wrap(pv[c-4], 26));
      end else begin
        check({name, "_rv0"}, 32'(bus.res_valid), 32'd0);
      end
      if (c == n + 4) begin
        check({name, "_hold"}, 32'(bus.res_data), wrap(pv[n-1], 26));
        check({name, "_busy0"}, 32'(bus.busy), 32'd0);
      end
    end
  endtask

  initial begin
    int av[8];
    int bv[8];
    int pv[8];
    int prod[4];

    bus.en    = 1'b1;
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    #2;
    reset_n = 1'b0;
    bus.req = 4'b1111;
    #1;
    check("rst_gnt", 32'(bus.grant), 32'd0);
    bus.req = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst_rv", 32'(bus.res_valid), 32'd0);
    check("rst_rd", 32'(bus.res_data), 32'd0);
    check("rst_da", 32'(bus.mult_dataa), 32'd0);
    check("rst_db", 32'(bus.mult_datab), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // 1: single op 100 * -3
    av = '{100, 0, 0, 0, 0, 0, 0, 0};
    bv = '{-3, 0, 0, 0, 0, 0, 0, 0};
    pv = '{-300, 0, 0, 0, 0, 0, 0, 0};
    stream("t1", 0, 1, av, bv, pv);

    // 2: all four requesting for 8 cycles, round-robin 0,1,2,3,...
    do_reset();
    prod = '{20, 60, 120, 200};
    for (int i = 0; i < 4; i++) set_op(i, 10 * (i + 1), i + 2);
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      bus.req = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      check("t2_gnt", 32'(bus.grant), (c < 8) ? (32'd1 << (c % 4)) : 32'd0);
      if (c >= 4) begin
        check("t2_rv", 32'(bus.res_valid), 32'd1 << ((c - 4) % 4));
        check("t2_rd", 32'(bus.res_data), wrap(prod[(c - 4) % 4], 26));
      end
    end

    // 3: operand extremes through requester 1
    av = '{-8192, 8191, -8192, 0, 0, 0, 0, 0};
    bv = '{-2048, 2047, 2047, 0, 0, 0, 0, 0};
    pv = '{16777216, 16766977, -16769024, 0, 0, 0, 0, 0};
    stream("t3", 1, 3, av, bv, pv);

    // 4: requester 2 alone, 5 back-to-back ops
    av = '{100, 200, 300, 400, 500, 0, 0, 0};
    bv = '{3, 3, 3, 3, -3, 0, 0, 0};
    pv = '{300, 600, 900, 1200, -1500, 0, 0, 0};
    stream("t4", 2, 5, av, bv, pv);

    // 5: en drops after two grants; in-flight results still arrive
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 10 * (i + 1), i + 2);
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      bus.req = 4'b1111;
      bus.en  = (c < 2);
      #1;
      check("t5_gnt", 32'(bus.grant), (c < 2) ? (32'd1 << c) : 32'd0);
      check("t5_rv", 32'(bus.res_valid), (c == 4) ? 32'd1 : (c == 5) ? 32'd2 : 32'd0);
      if (c == 4) check("t5_rd", 32'(bus.res_data), 32'd20);
      if (c == 5) begin
        check("t5_rd", 32'(bus.res_data), 32'd60);
        check("t5_busy1", 32'(bus.busy), 32'd1);
      end
      if (c == 6) check("t5_busy0", 32'(bus.busy), 32'd0);
    end

    // 6: reset after three grants discards in-flight ops
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      bus.req = 4'b1111;
      #1;
      check("t6_gnt", 32'(bus.grant), 32'd1 << c);
    end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("t6_rgnt", 32'(bus.grant), 32'd0);
    check("t6_rda", 32'(bus.mult_dataa), 32'd0);
    check("t6_rrv", 32'(bus.res_valid), 32'd0);
    check("t6_rrd", 32'(bus.res_data), 32'd0);
    check("t6_rbusy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clock);
    bus.req = '0;
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      #1;
      check("t6_norv", 32'(bus.res_valid), 32'd0);
    end
    @(negedge clock);
    bus.req = 4'b1111;
    #1;
    check("t6_ptr", 32'(bus.grant), 32'd1);
    @(negedge clock);
    bus.req = '0;
    repeat (6) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
